// File: rtl/rs_pkg.sv
// Shared GF(2^8) constants, arithmetic helpers and FSM type
// for the Reed-Solomon LFSR encoder.
package rs_pkg;

  localparam logic [8:0] GF_POLY = 9'h11D;
  localparam int NPAR_MAX = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY
  } rs_state_e;

  function automatic logic [7:0] gf_xtime(
    input logic [7:0] a
  );
    logic [7:0] r;
    r = {a[6:0], 1'b0};
    if (a[7]) r = r ^ GF_POLY[7:0];
    return r;
  endfunction

  function automatic logic [7:0] gf_mul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = gf_xtime(x);
    end
    return p;
  endfunction

  // g(x) = prod (x + a^i), i = 0..npar-1; returns the x^idx term.
  function automatic logic [7:0] gen_coef(
    input int npar,
    input int idx
  );
    logic [7:0] c [0:NPAR_MAX];
    logic [7:0] r;
    for (int j = 0; j <= NPAR_MAX; j++) c[j] = 8'h00;
    c[0] = 8'h01;
    r    = 8'h01;
    for (int i = 0; i < NPAR_MAX; i++) begin
      if (i < npar) begin
        for (int j = NPAR_MAX; j >= 1; j--)
          c[j] = c[j-1] ^ gf_mul(c[j], r);
        c[0] = gf_mul(c[0], r);
        r    = gf_xtime(r);
      end
    end
    return c[idx];
  endfunction

endpackage

// File: rtl/gf_cmul.sv
// Combinational GF(2^8) multiply of an operand by constant C;
// the constant folds the partial products down to an XOR tree.
module gf_cmul
  import rs_pkg::*;
#(
  parameter logic [7:0] C = 8'h01
) (
  input  logic [7:0] a,
  output logic [7:0] y
);

  logic [7:0] acc;
  logic [7:0] shf;

  always_comb begin
    acc = 8'h00;
    shf = a;
    for (int j = 0; j < 8; j++) begin
      if (C[j]) acc = acc ^ shf;
      shf = gf_xtime(shf);
    end
    y = acc;
  end

endmodule

// File: rtl/rs_enc_lfsr.sv
// Systematic RS(K+NPAR,K) encoder over GF(2^8), valid/ready both sides.
// Define RS_SHORT_EN for the per-frame shortened length port k_len.
module rs_enc_lfsr
  import rs_pkg::*;
#(
  parameter int NPAR = 16,
  parameter int K    = 239
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
`ifdef RS_SHORT_EN
  input  logic [7:0] k_len,
`endif
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_sop,
  output logic       out_last,
  output logic       out_par
);

  localparam logic [7:0] K8    = 8'(K);
  localparam logic [7:0] NPAR8 = 8'(NPAR);

  rs_state_e  state_q, state_d;
  logic [7:0] par_q [NPAR];
  logic [7:0] par_d [NPAR];
  logic [7:0] fbm   [NPAR];
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] klen_q, klen_d;

  logic       ov_q, ov_d;
  logic [7:0] od_q, od_d;
  logic       sop_q, sop_d;
  logic       last_q, last_d;
  logic       pf_q, pf_d;

  logic [7:0] fb;
  logic [7:0] klen_in;
  logic [7:0] klen_cur;
  logic       slot_free;
  logic       in_acc;

`ifdef RS_SHORT_EN
  assign klen_in = (k_len == 8'd0 || k_len > K8) ? K8 : k_len;
`else
  assign klen_in = K8;
`endif

  assign klen_cur  = (state_q == S_IDLE) ? klen_in : klen_q;
  assign slot_free = !ov_q || out_ready;
  assign in_ready  = !rst && slot_free && (state_q != S_PARITY);
  assign in_acc    = in_valid && in_ready;
  assign fb        = in_data ^ par_q[NPAR-1];

  for (genvar i = 0; i < NPAR; i++) begin : g_tap
    gf_cmul #(
      .C (gen_coef(NPAR, i))
    ) u_cmul (
      .a (fb),
      .y (fbm[i])
    );
  end

  always_comb begin
    state_d = state_q;
    par_d   = par_q;
    cnt_d   = cnt_q;
    klen_d  = klen_q;
    ov_d    = ov_q;
    od_d    = od_q;
    sop_d   = sop_q;
    last_d  = last_q;
    pf_d    = pf_q;
    if (slot_free) begin
      ov_d   = 1'b0;
      sop_d  = 1'b0;
      last_d = 1'b0;
      pf_d   = 1'b0;
      unique case (1'b1)
        in_acc: begin
          ov_d  = 1'b1;
          od_d  = in_data;
          sop_d = (state_q == S_IDLE);
          par_d[0] = fbm[0];
          for (int i = 1; i < NPAR; i++)
            par_d[i] = par_q[i-1] ^ fbm[i];
          cnt_d = cnt_q + 8'd1;
          if (state_q == S_IDLE) klen_d = klen_in;
          if (cnt_q + 8'd1 == klen_cur) state_d = S_PARITY;
          else                          state_d = S_DATA;
        end
        (state_q == S_PARITY): begin
          ov_d = 1'b1;
          od_d = par_q[NPAR-1];
          pf_d = 1'b1;
          par_d[0] = 8'h00;
          for (int i = 1; i < NPAR; i++)
            par_d[i] = par_q[i-1];
          // counter runs on through parity; frame ends at klen+NPAR-1
          if (cnt_q == klen_q + NPAR8 - 8'd1) begin
            last_d  = 1'b1;
            cnt_d   = 8'd0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      for (int i = 0; i < NPAR; i++) par_q[i] <= 8'h00;
      cnt_q  <= 8'd0;
      klen_q <= K8;
      ov_q   <= 1'b0;
      od_q   <= 8'h00;
      sop_q  <= 1'b0;
      last_q <= 1'b0;
      pf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      par_q   <= par_d;
      cnt_q   <= cnt_d;
      klen_q  <= klen_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
      sop_q   <= sop_d;
      last_q  <= last_d;
      pf_q    <= pf_d;
    end
  end

  assign out_valid = ov_q;
  assign out_data  = od_q;
  assign out_sop   = sop_q;
  assign out_last  = last_q;
  assign out_par   = pf_q;

endmodule

// File: tb/tb_rs_enc_lfsr.sv
// Self-checking bench for rs_enc_lfsr against a polynomial-division
// reference model built from GF log/antilog tables.
module tb_rs_enc_lfsr;

  localparam int NPAR = 16;
  localparam int K    = 239;
  localparam int N    = K + NPAR;

  typedef logic [7:0] bq_t [$];
  typedef struct {
    logic [7:0] d;
    logic       s;
    logic       l;
    logic       p;
  } osym_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_sop;
  logic       out_last;
  logic       out_par;
`ifdef RS_SHORT_EN
  logic [7:0] k_len;
`endif

  rs_enc_lfsr #(.NPAR(NPAR), .K(K)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
`ifdef RS_SHORT_EN
    .k_len     (k_len),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sop   (out_sop),
    .out_last  (out_last),
    .out_par   (out_par)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  int exp_t [0:254];
  int log_t [0:255];
  logic [7:0] gl [0:NPAR];
  logic [7:0] gh [0:NPAR];

  bq_t   in_q;
  osym_t out_q [$];
  int    max_streak;
  int    par_viol;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    if (a == 0 || b == 0) return 8'h00;
    return 8'(exp_t[(log_t[a] + log_t[b]) % 255]);
  endfunction

  function automatic bq_t parity_of(input bq_t m);
    bq_t p;
    bq_t r;
    logic [7:0] c;
    p = m;
    for (int j = 0; j < NPAR; j++) p.push_back(8'h00);
    for (int i = 0; i < m.size(); i++) begin
      c = p[i];
      if (c != 0)
        for (int j = 1; j <= NPAR; j++) p[i+j] = p[i+j] ^ gmul(c, gh[j]);
    end
    for (int j = 0; j < NPAR; j++) r.push_back(p[m.size()+j]);
    return r;
  endfunction

  function automatic bq_t rand_msg(input int n);
    bq_t m;
    for (int i = 0; i < n; i++) m.push_back(8'($urandom));
    return m;
  endfunction

  task automatic run(input int n_out, input bit rnd, input int budget,
                     input bit dummy);
    int  cyc = 0;
    int  streak = 0;
    bit  last_seen = 0;
    out_q.delete();
    max_streak = 0;
    par_viol   = 0;
    while (out_q.size() < n_out && cyc < budget) begin
      @(negedge clk);
      if (out_valid && out_last) last_seen = 1;
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (in_q.size() > 0) begin
        in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        in_data  = in_q[0];
      end else if (dummy && !last_seen) begin
        in_valid = 1'b1;
        in_data  = 8'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid) streak++;
      else streak = 0;
      if (streak > max_streak) max_streak = streak;
      if (dummy && in_q.size() == 0 && !last_seen && in_ready)
        par_viol++;
      if (in_valid && in_ready) void'(in_q.pop_front());
      if (out_valid && out_ready)
        out_q.push_back('{d: out_data, s: out_sop, l: out_last,
                          p: out_par});
      cyc++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("outputs_collected", out_q.size(), n_out);
  endtask

  task automatic check_frame(input string tag, input bq_t msg,
                             input int base);
    bq_t full;
    bq_t par;
    int kl = msg.size();
    int dm = 0;
    int fm = 0;
    osym_t o;
    logic [7:0] ed;
    for (int i = 0; i < K - kl; i++) full.push_back(8'h00);
    foreach (msg[i]) full.push_back(msg[i]);
    par = parity_of(full);
    for (int j = 0; j < kl + NPAR; j++) begin
      o  = out_q[base + j];
      ed = (j < kl) ? msg[j] : par[j - kl];
      if (o.d !== ed) dm++;
      if (o.s !== (j == 0) || o.l !== (j == kl + NPAR - 1) ||
          o.p !== (j >= kl)) fm++;
    end
    chk({tag, "_data_errs"}, dm, 0);
    chk({tag, "_flag_errs"}, fm, 0);
  endtask

  bq_t m_zero, m_imp, m_a, m_b, m_x, m_c, m_d, pa, pb, px;
  int  err;

  initial begin
    int x = 1;
    for (int i = 0; i < 255; i++) begin
      exp_t[i] = x;
      log_t[x] = i;
      x = x << 1;
      if (x & 'h100) x = x ^ 'h11D;
    end
    for (int j = 0; j <= NPAR; j++) gl[j] = 8'h00;
    gl[0] = 8'h01;
    for (int i = 0; i < NPAR; i++) begin
      for (int j = NPAR; j >= 1; j--)
        gl[j] = gl[j-1] ^ gmul(gl[j], 8'(exp_t[i]));
      gl[0] = gmul(gl[0], 8'(exp_t[i]));
    end
    for (int j = 0; j <= NPAR; j++) gh[j] = gl[NPAR - j];

    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    out_ready = 1'b0;
`ifdef RS_SHORT_EN
    k_len = 8'd0;
`endif
    #12;
    chk("reset_outputs",
        {out_valid, out_sop, out_last, out_par, in_ready, out_data}, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_reset_in_ready", in_ready, 1);
    chk("post_reset_out_valid", out_valid, 0);

    for (int i = 0; i < K; i++) m_zero.push_back(8'h00);
    in_q = m_zero;
    run(N, 0, 400, 0);
    check_frame("zero", m_zero, 0);
    chk("zero_sop0", out_q[0].s, 1);
    chk("zero_last254", out_q[N-1].l, 1);

    m_imp = m_zero;
    m_imp[K-1] = 8'h01;
    in_q = m_imp;
    run(N, 0, 400, 0);
    err = 0;
    for (int j = 0; j < NPAR; j++)
      if (out_q[K+j].d !== gl[NPAR-1-j]) err++;
    chk("impulse_parity_is_g", err, 0);
    check_frame("impulse", m_imp, 0);

    m_a = rand_msg(K);
    m_b = rand_msg(K);
    foreach (m_a[i]) m_x.push_back(m_a[i] ^ m_b[i]);
    in_q = m_a;
    run(N, 0, 400, 0);
    check_frame("msg_a", m_a, 0);
    for (int j = 0; j < NPAR; j++) pa.push_back(out_q[K+j].d);
    in_q = m_b;
    run(N, 0, 400, 0);
    check_frame("msg_b", m_b, 0);
    for (int j = 0; j < NPAR; j++) pb.push_back(out_q[K+j].d);
    in_q = m_x;
    run(N, 0, 400, 0);
    check_frame("msg_axb", m_x, 0);
    for (int j = 0; j < NPAR; j++) px.push_back(out_q[K+j].d);
    err = 0;
    for (int j = 0; j < NPAR; j++)
      if (px[j] !== (pa[j] ^ pb[j])) err++;
    chk("linearity", err, 0);

    in_q = m_a;
    run(N, 1, 4000, 1);
    check_frame("stall_a", m_a, 0);
    chk("in_ready_low_in_parity", par_viol, 0);

    in_q = m_b;
    foreach (m_x[i]) in_q.push_back(m_x[i]);
    run(2*N, 0, 800, 0);
    check_frame("b2b_first", m_b, 0);
    check_frame("b2b_second", m_x, N);
    chk("b2b_valid_streak", max_streak, 2*N);
    chk("b2b_sop_after_last", {out_q[N-1].l, out_q[N].s}, 2'b11);

    m_c = rand_msg(K);
    in_q = m_c;
    run(K + 5, 0, 400, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset_outputs",
        {out_valid, out_sop, out_last, out_par, in_ready, out_data}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    in_q.delete();
    m_d = rand_msg(K);
    in_q = m_d;
    run(N, 0, 400, 0);
    check_frame("after_reset", m_d, 0);

`ifdef RS_SHORT_EN
    k_len = 8'd100;
    in_q = rand_msg(100);
    m_d = in_q;
    run(100 + NPAR, 0, 400, 0);
    check_frame("short100", m_d, 0);
    k_len = 8'd0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
